// File: rtl/eqv_sweep_ctrl_pkg.sv
// Shared types and constants for the XOR-equivalence sweep controller.
// The state encoding is fixed so that external probes can decode it.
package eqv_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int VEC_W = 2;
  localparam logic [VEC_W-1:0] LAST_VEC = 2'b11;
endpackage

// File: rtl/eqv_sweep_ctrl_if.sv
// Sweep bus: operand drive, network responses and sweep status/result.
// master is the controller side; slave is the environment/network side.
interface eqv_sweep_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             start;
  logic             a;
  logic             b;
  logic             x;
  logic             y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mism_cnt;
  logic [1:0]       fail_vec;

  modport master (
    input  start, a, b,
    output x, y, busy, done, pass, mism_cnt, fail_vec
  );

  modport slave (
    output start, a, b,
    input  x, y, busy, done, pass, mism_cnt, fail_vec
  );
endinterface

// File: rtl/eqv_settle_timer.sv
// Loadable down-counter; expired is high in the last of SETTLE_CYCLES enabled cycles.
// Latency: load -> expiry after SETTLE_CYCLES enabled cycles; no backpressure.
module eqv_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= 4'(SETTLE_CYCLES - 1);
    end else if (en && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign expired = en && (cnt_q == 4'd0);
endmodule

// File: rtl/eqv_sweep_ctrl.sv
// Exhaustive 2-input sweep comparing a gate network against a reference; done 4*(SETTLE_CYCLES+1)
// cycles after start accept. Optional EQV_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module eqv_sweep_ctrl
  import eqv_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 3
) (
  input  logic              clk,
  input  logic              reset,
  eqv_sweep_ctrl_if.master  bus
);
  state_t            state_q, state_d;
  logic [VEC_W-1:0]  vec_q;
  logic [CNT_W-1:0]  cnt_q, cnt_inc;
  logic [1:0]        fv_q;
  logic              pass_q;
  logic              accept, mism, last, settle_exp, tmr_load;
  logic              busy, done;

  assign accept   = (state_q == IDLE) && bus.start;
  assign mism     = (bus.a != bus.b);
  assign last     = (vec_q == LAST_VEC);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign tmr_load = accept || (state_q == CHECK && state_d == SETTLE);

  eqv_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .en      (state_q == SETTLE),
    .expired (settle_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.start) state_d = SETTLE;
      SETTLE: if (settle_exp) state_d = CHECK;
`ifdef EQV_STOP_ON_FAIL_EN
      CHECK:  state_d = (mism || last) ? DONE : SETTLE;
`else
      CHECK:  state_d = last ? DONE : SETTLE;
`endif
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SETTLE, CHECK: busy = 1'b1;
      DONE:          done = 1'b1;
      default: ;
    endcase
  end

  // Results are cleared only by an accepted start, so they persist through IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q  <= '0;
      cnt_q  <= '0;
      fv_q   <= 2'b00;
      pass_q <= 1'b0;
    end else if (accept) begin
      vec_q  <= '0;
      cnt_q  <= '0;
      fv_q   <= 2'b00;
      pass_q <= 1'b0;
    end else if (state_q == CHECK) begin
      if (mism) begin
        cnt_q <= cnt_inc;
        if (cnt_q == '0) fv_q <= vec_q;
      end
      if (state_d == SETTLE) vec_q <= vec_q + 1'b1;
      if (state_d == DONE)   pass_q <= !mism && (cnt_q == '0);
    end
  end

  assign bus.x        = vec_q[1];
  assign bus.y        = vec_q[0];
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.pass     = pass_q;
  assign bus.mism_cnt = cnt_q;
  assign bus.fail_vec = fv_q;
endmodule

// File: doc/eqv_sweep_ctrl.md
EQV_SWEEP_CTRL -- requirements
Module: eqv_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles held on each input vector before sampling; legal range 1..15.
REQ-002 Parameter CNT_W, default 3: width of the mismatch counter; minimum 3.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request one exhaustive sweep; sampled only in IDLE.
REQ-006 a  input  1  output of the gate network under test (NOR-built XOR).
REQ-007 b  input  1  output of the behavioural reference gate.
REQ-008 x  output  1  first operand driven to both networks; registered.
REQ-009 y  output  1  second operand driven to both networks; registered.
REQ-010 busy  output  1  high from the start-accept edge until DONE is entered.
REQ-011 done  output  1  single-cycle pulse when the sweep ends.
REQ-012 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-013 mism_cnt  output  CNT_W  mismatches in the current or last sweep.
REQ-014 fail_vec  output  2  {x,y} of the first mismatching vector; 2'b00 if none.

Function
REQ-015 FSM states: IDLE, SETTLE, CHECK, DONE.
REQ-016 Vector order: {x,y} = 00, 01, 10, 11.
REQ-017 IDLE with start=1: on that edge load {x,y}=00, clear mism_cnt, fail_vec and pass, clear the settle counter, and go to SETTLE.
REQ-018 SETTLE lasts exactly SETTLE_CYCLES cycles, then goes to CHECK; x and y stay stable.
REQ-019 CHECK lasts one cycle; at its closing edge a and b are compared.
REQ-020 Mismatch (a!=b): increment mism_cnt, saturating at all-ones; if it is the first mismatch, capture {x,y} into fail_vec.
REQ-021 After CHECK on vector 11: go to DONE. Otherwise advance {x,y} by one and go to SETTLE.
REQ-022 DONE lasts one cycle with done=1 and busy=0. pass is set on entry (mism_cnt==0), then the FSM returns to IDLE.
REQ-023 Latency: done is high in the cycle starting 4*(SETTLE_CYCLES+1) edges after the start-accept edge.
REQ-024 start is ignored in SETTLE, CHECK and DONE; it is not queued.
REQ-025 pass, mism_cnt and fail_vec hold their values in IDLE until the next start is accepted.
REQ-026 x and y hold their last vector in IDLE and DONE.

Reset
REQ-027 reset=1 at any edge, including mid-sweep: state goes to IDLE, and x, y, busy, done, pass, mism_cnt and fail_vec all go to 0.
REQ-028 reset has priority over start in the same cycle.

Configuration
REQ-029 Macro EQV_STOP_ON_FAIL_EN, when defined: the first mismatch in CHECK sends the FSM directly to DONE, skipping the remaining vectors, with mism_cnt=1.
REQ-030 Without EQV_STOP_ON_FAIL_EN: all four vectors are always checked, per REQ-021.

Structure
REQ-031 Shared package eqv_pkg holds:
- the state encoding typedef (IDLE=0, SETTLE=1, CHECK=2, DONE=3);
- the vector-width constant (2);
- the last-vector constant (2'b11).
REQ-032 One sub-module, eqv_settle_timer: a loadable down-counter that flags expiry after SETTLE_CYCLES cycles.

Verification
REQ-033 a=b from matching XOR networks, SETTLE_CYCLES=2, pulse start -> x,y step through 00,01,10,11; done is high 12 cycles after accept; pass=1, mism_cnt=0, fail_vec=00.
REQ-034 a driven by x|y and b by x^y, flag undefined -> mism_cnt=1, fail_vec=11, pass=0.
REQ-035 a tied to 1 and b to x^y, flag undefined -> mism_cnt=2, fail_vec=00; with EQV_STOP_ON_FAIL_EN, done is high 3 cycles after accept with mism_cnt=1, fail_vec=00.
REQ-036 start held high for the whole sweep -> exactly one sweep and one done pulse; a new sweep begins only from IDLE.
REQ-037 reset asserted during SETTLE of vector 10 -> the next cycle is IDLE with all outputs 0, and a subsequent start runs a full sweep from 00.
REQ-038 reset and start both high in IDLE -> state stays IDLE and busy=0.
